// File: rtl/ham_16_11_pkg.sv
// Shared constants for the Hamming (16,11) SECDED code: widths, bit map and injection modes.
package ham_16_11_pkg;

  localparam int DATA_W   = 11;
  localparam int CODE_W   = 16;
  localparam int HAM_W    = 15;
  localparam int GPAR_IDX = 15;

  // Codeword bit index of Hamming parity bits (positions 1, 2, 4, 8).
  localparam int PAR_IDX [4] = '{0, 1, 3, 7};
  // Codeword bit index carrying data bit i.
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_GPAR   = 2'b11
  } inj_mode_e;

  // Codeword bits (positions 1..15) whose position index has bit k set.
  function automatic logic [HAM_W-1:0] par_cover(input int k);
    logic [HAM_W-1:0] m;
    m = '0;
    for (int i = 0; i < HAM_W; i++) begin
      m[i] = ((((i + 1) >> k) & 1) != 0);
    end
    return m;
  endfunction

  function automatic logic [CODE_W-1:0] inj_mask(input inj_mode_e mode);
    logic [CODE_W-1:0] m;
    m = '0;
    case (mode)
      INJ_SINGLE: m[PAR_IDX[0]] = 1'b1;
      INJ_DOUBLE: begin
        m[PAR_IDX[0]]  = 1'b1;
        m[DATA_IDX[0]] = 1'b1;
      end
      INJ_GPAR:   m[GPAR_IDX] = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ham_16_11_enc_pipe_if.sv
// Valid/ready stream bundle; the source side uses master, the sink side uses slave.
interface ham_16_11_enc_pipe_if #(
  parameter int W = 11
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ham_16_11_enc.sv
// Combinational Hamming (16,11) SECDED encoder: 11-bit data in, 16-bit codeword out.
module ham_16_11_enc
  import ham_16_11_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W-1:0] code_o
);

  logic [HAM_W-1:0] dpos;
  logic [HAM_W-1:0] ham;

  always_comb begin
    dpos = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dpos[DATA_IDX[i]] = data_i[i];
    end
  end

  // Parity slots in dpos are zero, so each cover mask can include them safely.
  always_comb begin
    ham = dpos;
    for (int k = 0; k < 4; k++) begin
      ham[PAR_IDX[k]] = ^(dpos & par_cover(k));
    end
  end

  assign code_o = {^ham, ham};

endmodule

// File: rtl/ham_16_11_enc_pipe.sv
// Two-stage Hamming (16,11) SECDED encoder with valid/ready on both sides and a transfer counter.
// Optional error injection into stage 2 is built when HAM_ENC_ERR_INJ_EN is defined.
module ham_16_11_enc_pipe
  import ham_16_11_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ham_16_11_enc_pipe_if.slave    in_if,
  ham_16_11_enc_pipe_if.master   out_if,
  output logic [CNT_W-1:0]       cnt_o,
  input  logic                   inj_req_i,
  input  logic [1:0]             inj_mode_i,
  output logic                   inj_done_o
);

  logic [CODE_W-1:0] enc_code;
  logic              unused_enc_gpar;

  logic              s1_valid_q, s1_valid_d;
  logic [HAM_W-1:0]  s1_ham_q, s1_ham_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CODE_W-1:0] s2_code_q, s2_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s1_advance;
  logic              in_ready;
  logic              in_fire;
  logic              s2_load;
  logic              out_fire;
  logic [CODE_W-1:0] inj_flip;

  ham_16_11_enc u_enc (
    .data_i (in_if.data),
    .code_o (enc_code)
  );

  // Global parity is recomputed in stage 2 from the registered Hamming word.
  assign unused_enc_gpar = enc_code[GPAR_IDX];

  assign s1_advance = !s2_valid_q | out_if.ready;
  assign in_ready   = !s1_valid_q | s1_advance;
  assign in_fire    = in_if.valid & in_ready;
  assign s2_load    = s1_valid_q & s1_advance;
  assign out_fire   = s2_valid_q & out_if.ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ham_d   = s1_ham_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    cnt_d      = cnt_q;
    if (s1_advance) begin
      s1_valid_d = 1'b0;
      s2_valid_d = s1_valid_q;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_ham_d   = enc_code[HAM_W-1:0];
    end
    if (s2_load) begin
      s2_code_d = {^s1_ham_q, s1_ham_q} ^ inj_flip;
    end
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_ham_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ham_q   <= s1_ham_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef HAM_ENC_ERR_INJ_EN
  logic      arm_q, arm_d;
  inj_mode_e mode_q, mode_d;
  logic      inj_done_q, inj_done_d;
  logic      eff_arm;
  inj_mode_e eff_mode;
  logic      inj_apply;

  // A request in the same cycle as the stage-2 load takes effect on that word.
  always_comb begin
    eff_arm  = arm_q;
    eff_mode = mode_q;
    if (inj_req_i) begin
      eff_mode = inj_mode_e'(inj_mode_i);
      eff_arm  = (inj_mode_e'(inj_mode_i) != INJ_NONE);
    end
    inj_apply  = s2_load & eff_arm;
    inj_flip   = inj_apply ? inj_mask(eff_mode) : '0;
    arm_d      = eff_arm & !inj_apply;
    mode_d     = eff_mode;
    inj_done_d = inj_apply;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_q      <= 1'b0;
      mode_q     <= INJ_NONE;
      inj_done_q <= 1'b0;
    end else begin
      arm_q      <= arm_d;
      mode_q     <= mode_d;
      inj_done_q <= inj_done_d;
    end
  end

  assign inj_done_o = inj_done_q;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req_i, inj_mode_i};
  assign inj_flip   = '0;
  assign inj_done_o = 1'b0;
`endif

  assign in_if.ready  = in_ready;
  assign out_if.data  = s2_code_q;
  assign out_if.valid = s2_valid_q;
  assign cnt_o        = cnt_q;

endmodule
